servo_pwm_bank: RTL and testbench

SERVO_PWM_BANK -- requirements
Module: servo_pwm_bank

---
 rtl/servo_pwm_bank.sv | 113 +++++++++++
 tb/tb_servo_pwm_bank.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/servo_pwm_bank.sv
// rtl/servo_pwm_bank.sv - bank of servo PWM channels with frame-aligned width updates
// Optional feature macro: SERVO_SLEW_EN limits each frame's width change to SLEW_STEP cycles.
module servo_pwm_bank #(
  parameter int NUM_CH      = 3,
  parameter int PERIOD_CYC  = 1000000,
  parameter int PW_W        = 20,
  parameter int RESET_WIDTH = 75000,
  parameter int SLEW_STEP   = 500,
  localparam int SEL_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              ch_wr,
  input  logic [SEL_W-1:0]  ch_sel,
  input  logic [PW_W-1:0]   ch_width,
  output logic              ch_ready,
  output logic              wr_drop,
  output logic [NUM_CH-1:0] pwm_out,
  output logic              frame_start,
  output logic [NUM_CH-1:0] settled
);

  // The counter shares the pulse-width field width, since a width of PERIOD_CYC must be representable.
  localparam logic [PW_W-1:0] LAST_CNT = PW_W'(PERIOD_CYC - 1);
  localparam logic [PW_W-1:0] MAX_W    = PW_W'(PERIOD_CYC);
  localparam logic [PW_W-1:0] RST_W    = PW_W'(RESET_WIDTH);
`ifdef SERVO_SLEW_EN
  localparam logic [PW_W-1:0] STEP_W   = PW_W'(SLEW_STEP);
`endif

  if (NUM_CH < 1 || NUM_CH > 16 || PERIOD_CYC < 2 || RESET_WIDTH > PERIOD_CYC ||
      SLEW_STEP < 1 || PERIOD_CYC >= (1 << PW_W)) begin : g_bad_params
    $error("servo_pwm_bank: parameter out of range");
  end

  logic [PW_W-1:0]              cnt_q, cnt_d;
  logic                         running_q, running_d;
  logic [NUM_CH-1:0][PW_W-1:0]  target_q, target_d;
  logic [NUM_CH-1:0][PW_W-1:0]  active_q, active_d;
  logic [NUM_CH-1:0]            pwm_q, pwm_d;
  logic                         frame_start_q, frame_start_d;
  logic                         wr_drop_q, wr_drop_d;
  logic                         transfer, sel_ok, wr_ok;
  logic [PW_W-1:0]              wr_width;

  // Last counter value is the transfer cycle; writes are refused there so targets are stable.
  assign transfer    = (cnt_q == LAST_CNT);
  assign ch_ready    = running_q && !transfer;
  assign sel_ok      = (int'(ch_sel) < NUM_CH);
  assign wr_ok       = ch_wr && ch_ready && sel_ok;
  assign wr_width    = (ch_width > MAX_W) ? MAX_W : ch_width;
  assign pwm_out     = pwm_q;
  assign frame_start = frame_start_q;
  assign wr_drop     = wr_drop_q;

  // Settled flags compare active and target widths directly.
  always_comb begin
    settled = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      settled[i] = (active_q[i] == target_q[i]);
    end
  end

  // Next state: frame counter, host writes, frame-boundary transfer and registered outputs.
  always_comb begin
    cnt_d         = transfer ? '0 : cnt_q + 1'b1;
    running_d     = 1'b1;
    frame_start_d = (cnt_q == '0);
    wr_drop_d     = ch_wr && !(ch_ready && sel_ok);
    target_d      = target_q;
    active_d      = active_q;
    pwm_d         = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      pwm_d[i] = (cnt_q < active_q[i]);
      if (wr_ok && ch_sel == SEL_W'(i)) begin
        target_d[i] = wr_width;
      end
      if (transfer) begin
`ifdef SERVO_SLEW_EN
        if (target_q[i] > active_q[i]) begin
          active_d[i] = (target_q[i] - active_q[i] > STEP_W) ? active_q[i] + STEP_W : target_q[i];
        end else begin
          active_d[i] = (active_q[i] - target_q[i] > STEP_W) ? active_q[i] - STEP_W : target_q[i];
        end
`else
        active_d[i] = target_q[i];
`endif
      end
    end
  end

  // State registers; reset abandons the frame in progress and restores neutral widths.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      cnt_q         <= '0;
      running_q     <= 1'b0;
      target_q      <= {NUM_CH{RST_W}};
      active_q      <= {NUM_CH{RST_W}};
      pwm_q         <= '0;
      frame_start_q <= 1'b0;
      wr_drop_q     <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      running_q     <= running_d;
      target_q      <= target_d;
      active_q      <= active_d;
      pwm_q         <= pwm_d;
      frame_start_q <= frame_start_d;
      wr_drop_q     <= wr_drop_d;
    end
  end

endmodule

// File: tb/tb_servo_pwm_bank.sv
// tb/tb_servo_pwm_bank.sv - self-checking bench for servo_pwm_bank against a frame-level model
module tb_servo_pwm_bank;
  localparam int N = 3, P = 100, RW = 50, STEP = 10;
`ifdef SERVO_SLEW_EN
  localparam bit SLEW = 1'b1;
`else
  localparam bit SLEW = 1'b0;
`endif

  logic clock = 1'b0, resetn = 1'b0, ch_wr = 1'b0;
  logic [1:0] ch_sel = '0;
  logic [19:0] ch_width = '0;
  logic ch_ready, wr_drop, frame_start;
  logic [N-1:0] pwm_out, settled;

  int checks = 0, errors = 0;
  int m_cnt = 0;
  bit m_run = 1'b0;
  int m_tgt[N], m_act[N];
  int acc[N], lastw[N];
  int fs_gap = 0, last_gap = 0;

  servo_pwm_bank #(.NUM_CH(N), .PERIOD_CYC(P), .PW_W(20), .RESET_WIDTH(RW), .SLEW_STEP(STEP)) dut (
    .clock(clock), .resetn(resetn), .ch_wr(ch_wr), .ch_sel(ch_sel), .ch_width(ch_width),
    .ch_ready(ch_ready), .wr_drop(wr_drop), .pwm_out(pwm_out), .frame_start(frame_start),
    .settled(settled)
  );

  always #5 clock = ~clock;

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Width applied at a frame boundary: the target, or one bounded step toward it.
  function automatic int next_width(int a, int t);
    if (!SLEW) return t;
    if (t > a) return (t - a > STEP) ? a + STEP : t;
    return (a - t > STEP) ? a - STEP : t;
  endfunction

  // Model: position within the frame, per-channel requested and in-force widths.
  always @(posedge clock) begin
    int xp, xfs, xdrop, xready, xset;
    bit rdy;
    xp = 0; xfs = 0; xdrop = 0;
    if (!resetn) begin
      m_cnt = 0; m_run = 1'b0;
      for (int i = 0; i < N; i++) begin m_tgt[i] = RW; m_act[i] = RW; end
    end else begin
      rdy = m_run && (m_cnt != P - 1);
      xdrop = (ch_wr && (!rdy || ch_sel >= N)) ? 1 : 0;
      xfs = (m_cnt == 0) ? 1 : 0;
      for (int i = 0; i < N; i++) if (m_cnt < m_act[i]) xp |= (1 << i);
      if (ch_wr && rdy && ch_sel < N) m_tgt[ch_sel] = (ch_width > P) ? P : int'(ch_width);
      if (m_cnt == P - 1) for (int i = 0; i < N; i++) m_act[i] = next_width(m_act[i], m_tgt[i]);
      m_cnt = (m_cnt + 1) % P;
      m_run = 1'b1;
    end
    xready = (m_run && m_cnt != P - 1) ? 1 : 0;
    xset = 0;
    for (int i = 0; i < N; i++) if (m_act[i] == m_tgt[i]) xset |= (1 << i);
    #1;
    chk("pwm_out", int'(pwm_out), xp);
    chk("frame_start", int'(frame_start), xfs);
    chk("wr_drop", int'(wr_drop), xdrop);
    chk("ch_ready", int'(ch_ready), xready);
    chk("settled", int'(settled), xset);
    fs_gap++;
    for (int i = 0; i < N; i++) begin
      if (frame_start) begin lastw[i] = acc[i]; acc[i] = int'(pwm_out[i]); end
      else acc[i] += int'(pwm_out[i]);
    end
    if (frame_start) begin last_gap = fs_gap; fs_gap = 0; end
  end

  task automatic wait_cnt(int k);
    int n = 0;
    @(negedge clock);
    while (m_cnt != k && n < 300) begin @(negedge clock); n++; end
    if (m_cnt != k) chk("wait_cnt timeout", m_cnt, k);
  endtask

  task automatic wait_fs(int count);
    for (int c = 0; c < count; c++) begin
      int n = 0;
      @(negedge clock);
      while (!frame_start && n < 300) begin @(negedge clock); n++; end
      if (!frame_start) chk("wait_fs timeout", 0, 1);
    end
  endtask

  task automatic do_wr(int sel, int w);
    ch_wr = 1'b1; ch_sel = 2'(sel); ch_width = 20'(w);
    @(negedge clock);
    ch_wr = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin acc[i] = 0; lastw[i] = 0; end
    #2;
    chk("reset pwm_out", int'(pwm_out), 0);
    chk("reset ch_ready", int'(ch_ready), 0);
    chk("reset frame_start", int'(frame_start), 0);
    chk("reset wr_drop", int'(wr_drop), 0);
    repeat (3) @(negedge clock);
    resetn = 1'b1;
    @(negedge clock);
    chk("ready after release", int'(ch_ready), 1);
    wait_fs(3);
    chk("frame period", last_gap, 100);
    for (int i = 0; i < N; i++) chk("neutral width", lastw[i], 50);

    wait_cnt(40);
    do_wr(0, 20);
    wait_fs(1);
    chk("ch0 current frame", lastw[0], 50);
    wait_fs(1);
    chk("ch0 next frame", lastw[0], SLEW ? 40 : 20);
    chk("ch1 undisturbed", lastw[1], 50);
    chk("ch2 undisturbed", lastw[2], 50);

    wait_cnt(99);
    chk("ready at transfer", int'(ch_ready), 0);
    do_wr(0, 70);
    chk("drop at transfer", int'(wr_drop), 1);
    wait_fs(4);
    chk("ch0 unchanged after drop", lastw[0], 20);

    wait_cnt(10);
    do_wr(3, 10);
    chk("drop bad sel", int'(wr_drop), 1);
    chk("settled after bad sel", int'(settled), 7);

    wait_cnt(5);
    do_wr(2, 150);
    wait_fs(7);
    chk("ch2 clamped width", lastw[2], 100);
    chk("ch2 constant high", int'(pwm_out[2]), 1);

    wait_cnt(10);
    do_wr(1, 80);
    chk("settled1 after write", int'(settled[1]), 0);
    wait_fs(1);
    chk("ch1 old frame", lastw[1], 50);
    chk("settled1 after transfer 1", int'(settled[1]), SLEW ? 0 : 1);
    wait_fs(1);
    chk("ch1 frame 1", lastw[1], SLEW ? 60 : 80);
    chk("settled1 after transfer 2", int'(settled[1]), SLEW ? 0 : 1);
    wait_fs(1);
    chk("ch1 frame 2", lastw[1], SLEW ? 70 : 80);
    chk("settled1 after transfer 3", int'(settled[1]), 1);
    wait_fs(1);
    chk("ch1 frame 3", lastw[1], 80);

    for (int k = 0; k < 500; k++) begin
      @(negedge clock);
      ch_wr = ($urandom_range(0, 3) == 0);
      ch_sel = 2'($urandom_range(0, 3));
      ch_width = 20'($urandom_range(0, 130));
    end
    @(negedge clock);
    ch_wr = 1'b0;

    wait_cnt(20);
    do_wr(2, 0);
    wait_fs(12);
    chk("ch2 zero width", lastw[2], 0);

    wait_cnt(30);
    resetn = 1'b0;
    #1;
    chk("async reset pwm_out", int'(pwm_out), 0);
    chk("async reset ch_ready", int'(ch_ready), 0);
    repeat (3) @(negedge clock);
    resetn = 1'b1;
    wait_fs(3);
    for (int i = 0; i < N; i++) chk("width after reset", lastw[i], 50);
    chk("settled after reset", int'(settled), 7);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors + 1);
    $fatal(1, "watchdog");
  end
endmodule
